// File: rtl/nubus_mem_arbiter.sv
// Round-robin arbiter sharing the local memory port between the NuBus slave path
// and the on-card CPU/DMA requester, with a watchdog that force-terminates stalled accesses.
module nubus_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        nub_clkn,
  input  logic        reset,
  input  logic        slv_valid,
  input  logic [3:0]  slv_write,
  input  logic [31:0] slv_addr,
  input  logic [31:0] slv_wdata,
  output logic        slv_ready,
  output logic        slv_err,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] rdata_o,
  output logic        mem_valid_o,
  output logic [3:0]  mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        arb_busy_o,
  output logic        arb_owner_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Terminal count of the watchdog; unused when the watchdog is disabled.
  localparam int unsigned WD_LIMIT_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [7:0]  WD_LIMIT   = WD_LIMIT_I[7:0];
  localparam logic        WD_ENABLE  = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        mem_valid_q, mem_valid_d;
  logic [3:0]  mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic grant_cpu;
  logic done_ok;
  logic timed_out;
  logic finish;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_cnt_d     = wd_cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_cpu    = 1'b0;
    done_ok      = 1'b0;
    timed_out    = 1'b0;
    finish       = 1'b0;
    slv_ready    = 1'b0;
    slv_err      = 1'b0;
    cpu_ready    = 1'b0;
    cpu_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (slv_valid || cpu_valid) begin
          // On a tie the requester that did not own the previous access wins.
          grant_cpu   = cpu_valid && (!slv_valid || !last_owner_q);
          state_d     = BUSY;
          owner_d     = grant_cpu;
          mem_valid_d = 1'b1;
          mem_write_d = grant_cpu ? cpu_write : slv_write;
          mem_addr_d  = grant_cpu ? cpu_addr  : slv_addr;
          mem_wdata_d = grant_cpu ? cpu_wdata : slv_wdata;
          wd_cnt_d    = 8'd0;
        end
      end
      BUSY: begin
        done_ok   = mem_ready_i && mem_valid_q;
        timed_out = WD_ENABLE && (wd_cnt_q == WD_LIMIT) && !mem_ready_i;
        finish    = done_ok || timed_out;
        if (finish) begin
          state_d      = IDLE;
          mem_valid_d  = 1'b0;
          last_owner_d = owner_q;
        end else if (wd_cnt_q != 8'hFF) begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
        // A reset in the completion cycle abandons the access silently.
        slv_ready = finish && !owner_q && !reset;
        slv_err   = timed_out && !owner_q && !reset;
        cpu_ready = finish && owner_q && !reset;
        cpu_err   = timed_out && owner_q && !reset;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wd_cnt_q     <= 8'd0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_cnt_q     <= wd_cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign rdata_o     = mem_rdata_i;
  assign mem_valid_o = mem_valid_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign arb_busy_o  = (state_q == BUSY);
  assign arb_owner_o = owner_q;

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Self-checking bench for nubus_mem_arbiter: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_nubus_mem_arbiter;

  localparam int T8 = 8;

  logic        nub_clkn = 1'b0;
  logic        reset = 1'b1;
  logic        slv_valid = 1'b0, cpu_valid = 1'b0;
  logic [3:0]  slv_write = 4'd0, cpu_write = 4'd0;
  logic [31:0] slv_addr = 32'd0, slv_wdata = 32'd0, cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic        slv_ready, slv_err, cpu_ready, cpu_err;
  logic [31:0] rdata_o;
  logic        mem_valid_o;
  logic [3:0]  mem_write_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_ready_i = 1'b0;
  logic        arb_busy_o, arb_owner_o;

  // Second instance with the watchdog disabled; only its slave port is exercised.
  logic        z_slv_valid = 1'b0;
  logic [31:0] z_slv_addr = 32'd0, z_slv_wdata = 32'd0;
  logic        z_slv_ready, z_slv_err, z_cpu_ready, z_cpu_err;
  logic [31:0] z_rdata_o;
  logic        z_mem_valid_o;
  logic [3:0]  z_mem_write_o;
  logic [31:0] z_mem_addr_o, z_mem_wdata_o;
  logic [31:0] z_mem_rdata_i = 32'd0;
  logic        z_mem_ready_i = 1'b0;
  logic        z_arb_busy_o, z_arb_owner_o;
  logic        z_tie0 = 1'b0;
  logic [3:0]  z_tie4 = 4'd0;
  logic [31:0] z_tie32 = 32'd0;

  int nVectors = 0;
  int nMiscompares = 0;

  // Reference model state, kept at transaction level.
  bit          m_busy = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  bit          m_zero = 1'b1;
  int          m_age = 0;
  logic [3:0]  m_write = 4'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  bit          lastSlvDone = 1'b0, lastCpuDone = 1'b0;
  bit          lastObsErr = 1'b0;

  nubus_mem_arbiter #(.TIMEOUT_CYCLES(T8)) dut (
    .nub_clkn(nub_clkn), .reset(reset),
    .slv_valid(slv_valid), .slv_write(slv_write), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_ready(slv_ready), .slv_err(slv_err),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .rdata_o(rdata_o), .mem_valid_o(mem_valid_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i), .arb_busy_o(arb_busy_o), .arb_owner_o(arb_owner_o)
  );

  nubus_mem_arbiter #(.TIMEOUT_CYCLES(0)) dut0 (
    .nub_clkn(nub_clkn), .reset(reset),
    .slv_valid(z_slv_valid), .slv_write(z_tie4), .slv_addr(z_slv_addr), .slv_wdata(z_slv_wdata),
    .slv_ready(z_slv_ready), .slv_err(z_slv_err),
    .cpu_valid(z_tie0), .cpu_write(z_tie4), .cpu_addr(z_tie32), .cpu_wdata(z_tie32),
    .cpu_ready(z_cpu_ready), .cpu_err(z_cpu_err),
    .rdata_o(z_rdata_o), .mem_valid_o(z_mem_valid_o), .mem_write_o(z_mem_write_o),
    .mem_addr_o(z_mem_addr_o), .mem_wdata_o(z_mem_wdata_o), .mem_rdata_i(z_mem_rdata_i),
    .mem_ready_i(z_mem_ready_i), .arb_busy_o(z_arb_busy_o), .arb_owner_o(z_arb_owner_o)
  );

  always #5 nub_clkn = ~nub_clkn;

  // Single comparison point: counts every check and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven just after the falling edge;
  // check outputs, advance the model across the next rising edge.
  task automatic stepCycle();
    bit done, to, winCpu;
    bit expSr, expSe, expCr, expCe;
    #1;
    done  = m_busy && mem_ready_i && !reset;
    to    = m_busy && (m_age == T8 - 1) && !mem_ready_i && !reset;
    expSr = (done || to) && !m_owner;
    expCr = (done || to) && m_owner;
    expSe = to && !m_owner;
    expCe = to && m_owner;
    checkOutput("slv_ready", {31'd0, slv_ready}, {31'd0, expSr});
    checkOutput("slv_err", {31'd0, slv_err}, {31'd0, expSe});
    checkOutput("cpu_ready", {31'd0, cpu_ready}, {31'd0, expCr});
    checkOutput("cpu_err", {31'd0, cpu_err}, {31'd0, expCe});
    checkOutput("rdata", rdata_o, mem_rdata_i);
    checkOutput("mem_valid", {31'd0, mem_valid_o}, {31'd0, m_busy});
    checkOutput("arb_busy", {31'd0, arb_busy_o}, {31'd0, m_busy});
    checkOutput("arb_owner", {31'd0, arb_owner_o}, {31'd0, m_owner});
    if (m_busy || m_zero) begin
      checkOutput("mem_write", {28'd0, mem_write_o}, m_zero ? 32'd0 : {28'd0, m_write});
      checkOutput("mem_addr", mem_addr_o, m_zero ? 32'd0 : m_addr);
      checkOutput("mem_wdata", mem_wdata_o, m_zero ? 32'd0 : m_wdata);
    end
    lastSlvDone = expSr;
    lastCpuDone = expCr;
    lastObsErr  = slv_err | cpu_err;
    if (reset) begin
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_zero = 1'b1;
    end else if (m_busy) begin
      if (done || to) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else begin
        m_age++;
      end
    end else if (slv_valid || cpu_valid) begin
      winCpu  = (slv_valid && cpu_valid) ? !m_last : cpu_valid;
      m_busy  = 1'b1;
      m_owner = winCpu;
      m_age   = 0;
      m_zero  = 1'b0;
      m_write = winCpu ? cpu_write : slv_write;
      m_addr  = winCpu ? cpu_addr : slv_addr;
      m_wdata = winCpu ? cpu_wdata : slv_wdata;
    end
    @(negedge nub_clkn);
  endtask

  // Runs one access to completion; memory acks on busy cycle ackAt (0 = never).
  task automatic runAccess(input int ackAt, input logic [31:0] rdataVal, input bit keepValid,
                           output int cycles);
    cycles = 0;
    do begin
      mem_ready_i = m_busy && (ackAt > 0) && (m_age == ackAt - 1);
      mem_rdata_i = mem_ready_i ? rdataVal : $urandom;
      stepCycle();
      cycles++;
      if (lastSlvDone && !keepValid) slv_valid = 1'b0;
      if (lastCpuDone && !keepValid) cpu_valid = 1'b0;
    end while (!(lastSlvDone || lastCpuDone) && cycles < 40);
    if (!(lastSlvDone || lastCpuDone)) checkOutput("access_bound", 32'd0, 32'd1);
    mem_ready_i = 1'b0;
  endtask

  // Randomized protocol-legal traffic from both requesters and the memory.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0;
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (lastSlvDone) slv_valid = 1'b0;
      if (lastCpuDone) cpu_valid = 1'b0;
      if (!slv_valid && $urandom_range(0, 2) == 0) begin
        slv_valid = 1'b1; slv_write = 4'($urandom_range(0, 15));
        slv_addr = $urandom; slv_wdata = $urandom;
      end
      if (!cpu_valid && $urandom_range(0, 2) == 0) begin
        cpu_valid = 1'b1; cpu_write = 4'($urandom_range(0, 15));
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      mem_ready_i = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata_i = $urandom;
      stepCycle();
    end
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    int zErrs;
    bit expOwner [4];
    expOwner = '{1'b0, 1'b1, 1'b0, 1'b1};

    @(posedge nub_clkn);
    @(posedge nub_clkn);
    @(negedge nub_clkn);
    stepCycle();
    reset = 1'b0;
    stepCycle();

    $display("[TB] slave write alone");
    slv_valid = 1'b1; slv_addr = 32'hF900_0004; slv_write = 4'hF; slv_wdata = 32'hDEAD_BEEF;
    runAccess(3, 32'h0, 1'b0, cyc);
    checkOutput("slv_write_cycles", cyc, 32'd4);
    stepCycle();

    $display("[TB] cpu read");
    cpu_valid = 1'b1; cpu_write = 4'h0; cpu_addr = 32'h0000_0100;
    runAccess(2, 32'h1234_5678, 1'b0, cyc);
    checkOutput("cpu_read_cycles", cyc, 32'd3);
    stepCycle();

    $display("[TB] contention");
    reset = 1'b1; stepCycle(); reset = 1'b0;
    slv_valid = 1'b1; cpu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      runAccess(1, 32'h0, 1'b1, cyc);
      checkOutput("grant_order", {31'd0, arb_owner_o}, {31'd0, expOwner[i]});
    end
    slv_valid = 1'b0; cpu_valid = 1'b0;
    stepCycle();

    $display("[TB] watchdog");
    slv_valid = 1'b1; slv_addr = 32'h10;
    runAccess(0, 32'h0, 1'b0, cyc);
    checkOutput("wd_cycles", cyc, 32'd9);
    checkOutput("wd_err", {31'd0, lastObsErr}, 32'd1);
    stepCycle();
    slv_valid = 1'b1;
    runAccess(8, 32'hCAFE_F00D, 1'b0, cyc);
    checkOutput("wd_race_cycles", cyc, 32'd9);
    checkOutput("wd_race_err", {31'd0, lastObsErr}, 32'd0);
    stepCycle();

    $display("[TB] reset mid-access");
    cpu_valid = 1'b1; cpu_addr = 32'h44;
    stepCycle();
    stepCycle();
    reset = 1'b1; mem_ready_i = 1'b1;
    stepCycle();
    reset = 1'b0; mem_ready_i = 1'b0;
    slv_valid = 1'b1;
    stepCycle();
    checkOutput("post_reset_owner", {31'd0, arb_owner_o}, 32'd0);
    runAccess(1, 32'h0, 1'b0, cyc);
    runAccess(1, 32'h0, 1'b0, cyc);
    stepCycle();

    $display("[TB] random traffic");
    applyStimulus(3000);
    slv_valid = 1'b0; cpu_valid = 1'b0; mem_ready_i = 1'b0;
    reset = 1'b1; stepCycle(); reset = 1'b0; stepCycle();

    $display("[TB] watchdog disabled");
    z_slv_valid = 1'b1; z_slv_addr = 32'h200; z_slv_wdata = 32'h5A5A_5A5A;
    @(negedge nub_clkn);
    #1;
    checkOutput("z_mem_valid", {31'd0, z_mem_valid_o}, 32'd1);
    zErrs = 0;
    for (int i = 0; i < 300; i++) begin
      if (z_slv_ready || z_slv_err) zErrs++;
      @(negedge nub_clkn);
      #1;
    end
    checkOutput("z_no_term", zErrs, 32'd0);
    z_mem_ready_i = 1'b1; z_mem_rdata_i = 32'h0BAD_CAFE;
    #1;
    checkOutput("z_ready", {31'd0, z_slv_ready}, 32'd1);
    checkOutput("z_err", {31'd0, z_slv_err}, 32'd0);
    checkOutput("z_rdata", z_rdata_o, 32'h0BAD_CAFE);
    @(negedge nub_clkn);
    z_mem_ready_i = 1'b0; z_slv_valid = 1'b0;
    #1;
    checkOutput("z_mem_valid_off", {31'd0, z_mem_valid_o}, 32'd0);
    checkOutput("z_busy_off", {31'd0, z_arb_busy_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
